led_bank_arbiter: RTL and testbench

Round-robin arbiter that shares the board's single 8-bit LED bank (`ld`) between several on-chip requesters, e.g. the switch mirror, a counter display and a status pattern. It sits directly in front of the LED pins. It grants the bank to one requester at a time for a guaranteed minimum time slot. It registers the owner's pattern onto `ld`, and drives a fixed idle pattern when nobody is requesting.

---
 rtl/led_bank_arbiter.sv | 138 +++++++++++++
 tb/tb_led_bank_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing one 8-bit LED bank between NREQ requesters.
// Each grant lasts a minimum HOLD-cycle slot; the owner's pattern is registered onto ld.
module led_bank_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          HOLD         = 8,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00,
  localparam int         OW           = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int         CW           = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic [7:0]        ld
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_d;
  logic [NREQ-1:0]   gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        ld_d;

  logic [OW-1:0]     owner_inc;
  logic [NREQ-1:0]   others;
  logic [OW-1:0]     next_sel;
  logic              hold_end;

  // First asserted bit of r at or after index start, wrapping modulo NREQ.
  function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] r, input logic [OW-1:0] start);
    logic [2*NREQ-1:0] dbl;
    int off;
    int sum;
    dbl = {r, r} >> start;
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (dbl[k]) off = k;
    end
    sum = int'(start) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return OW'(sum);
  endfunction

  function automatic logic [7:0] pattern(input logic [8*NREQ-1:0] d, input logic [OW-1:0] i);
    return d[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  assign owner_inc = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign others    = req & ~gnt;
  assign next_sel  = pick(others, owner_inc);
  assign hold_end  = (cnt_q == CW'(HOLD - 1));
  assign busy      = (state_q == GRANT);

  // NOTE: every variable gets its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner;
    gnt_d   = gnt;
    cnt_d   = cnt_q;
    ld_d    = ld;
    case (state_q)
      IDLE: begin
        owner_d = '0;
        gnt_d   = '0;
        ld_d    = IDLE_PATTERN;
        if (|req) begin
          state_d = GRANT;
          owner_d = pick(req, ptr_q);
          gnt_d   = onehot(owner_d);
          cnt_d   = '0;
          ld_d    = pattern(data, owner_d);
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          // Release takes precedence over slot expiry; both advance ptr alike.
          ptr_d = owner_inc;
          cnt_d = '0;
          if (|others) begin
            owner_d = next_sel;
            gnt_d   = onehot(next_sel);
            ld_d    = pattern(data, next_sel);
          end else begin
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
            ld_d    = IDLE_PATTERN;
          end
        end else if (hold_end) begin
          cnt_d = '0;
          if (|others) begin
            ptr_d   = owner_inc;
            owner_d = next_sel;
            gnt_d   = onehot(next_sel);
            ld_d    = pattern(data, next_sel);
          end else begin
            ld_d = pattern(data, owner);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          ld_d  = pattern(data, owner);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner   <= '0;
      gnt     <= '0;
      cnt_q   <= '0;
      ld      <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner   <= owner_d;
      gnt     <= gnt_d;
      cnt_q   <= cnt_d;
      ld      <= ld_d;
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: a vector table, directed corner
// sequences and random traffic against a behavioural model, on HOLD=4 and HOLD=1.
module tb_led_bank_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;

  logic [N-1:0] gnt4, gnt1;
  logic [1:0]   own4, own1;
  logic         busy4, busy1;
  logic [7:0]   ld4, ld1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_bank_arbiter #(.NREQ(N), .HOLD(4), .IDLE_PATTERN(8'h00)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt4), .owner(own4), .busy(busy4), .ld(ld4)
  );

  led_bank_arbiter #(.NREQ(N), .HOLD(1), .IDLE_PATTERN(8'h00)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt1), .owner(own1), .busy(busy1), .ld(ld1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_hold[2] = '{4, 1};
  bit         m_busy[2];
  int         m_own[2];
  int         m_ptr[2];
  int         m_age[2];
  logic [7:0] m_ld[2] = '{8'h00, 8'h00};

  // First requester in circular order from start, skipping index skip; -1 if none.
  function automatic int scan(input logic [N-1:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int idx = (start + k) % N;
      if (idx != skip && ((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(data >> (8 * i));
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      int w;
      if (rst) begin
        m_busy[c] = 1'b0; m_own[c] = 0; m_ptr[c] = 0; m_age[c] = 0; m_ld[c] = 8'h00;
      end else if (!m_busy[c]) begin
        w = scan(req, m_ptr[c], -1);
        if (w >= 0) begin
          m_busy[c] = 1'b1; m_own[c] = w; m_age[c] = 0; m_ld[c] = pat(w);
        end else begin
          m_ld[c] = 8'h00;
        end
      end else if (((req >> m_own[c]) & 4'd1) == 4'd0) begin
        m_ptr[c] = (m_own[c] + 1) % N;
        w = scan(req, m_ptr[c], m_own[c]);
        m_age[c] = 0;
        if (w >= 0) begin
          m_own[c] = w; m_ld[c] = pat(w);
        end else begin
          m_busy[c] = 1'b0; m_own[c] = 0; m_ld[c] = 8'h00;
        end
      end else if (m_age[c] == m_hold[c] - 1) begin
        w = scan(req, (m_own[c] + 1) % N, m_own[c]);
        m_age[c] = 0;
        if (w >= 0) begin
          m_ptr[c] = (m_own[c] + 1) % N;
          m_own[c] = w;
        end
        m_ld[c] = pat(m_own[c]);
      end else begin
        m_age[c]++;
        m_ld[c] = pat(m_own[c]);
      end
    end
  endtask

  function automatic logic [31:0] m_gnt(input int c);
    return m_busy[c] ? (32'd1 << m_own[c]) : 32'd0;
  endfunction

  task automatic model_check();
    check("model_h4_gnt",   32'(gnt4),  m_gnt(0));
    check("model_h4_owner", 32'(own4),  32'(m_own[0]));
    check("model_h4_busy",  32'(busy4), 32'(m_busy[0]));
    check("model_h4_ld",    32'(ld4),   32'(m_ld[0]));
    check("model_h1_gnt",   32'(gnt1),  m_gnt(1));
    check("model_h1_owner", 32'(own1),  32'(m_own[1]));
    check("model_h1_busy",  32'(busy1), 32'(m_busy[1]));
    check("model_h1_ld",    32'(ld1),   32'(m_ld[1]));
  endtask

  // One clock edge: model advances on the same inputs, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) begin
      if (((g >> k) & 4'd1) != 4'd0) return k;
    end
    return 0;
  endfunction

  // ---------------- vector table (HOLD=4 instance) ----------------
  typedef struct packed {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [7:0]   ld;
  } vec_t;

  vec_t tbl[20];
  localparam logic [31:0] FIXED = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    int ow;
    logic [7:0] v;

    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 8'h00};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 8'h00};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 8'h11};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0001, 8'h11};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 8'h11};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0001, 8'h11};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0010, 8'h22};
    tbl[7]  = '{1'b0, 4'b1010, 4'b0010, 8'h22};
    tbl[8]  = '{1'b0, 4'b1000, 4'b1000, 8'h44};
    tbl[9]  = '{1'b0, 4'b1000, 4'b1000, 8'h44};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[11] = '{1'b0, 4'b0100, 4'b0100, 8'h33};
    tbl[12] = '{1'b0, 4'b0100, 4'b0100, 8'h33};
    tbl[13] = '{1'b0, 4'b0100, 4'b0100, 8'h33};
    tbl[14] = '{1'b0, 4'b0100, 4'b0100, 8'h33};
    tbl[15] = '{1'b0, 4'b0100, 4'b0100, 8'h33};
    tbl[16] = '{1'b0, 4'b0100, 4'b0100, 8'h33};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[18] = '{1'b0, 4'b0011, 4'b0001, 8'h11};
    tbl[19] = '{1'b1, 4'b0011, 4'b0000, 8'h00};

    rst  = 1'b1;
    req  = '0;
    data = FIXED;

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      step();
      check($sformatf("tbl%0d_gnt", i),   32'(gnt4),  32'(tbl[i].gnt));
      check($sformatf("tbl%0d_ld", i),    32'(ld4),   32'(tbl[i].ld));
      check($sformatf("tbl%0d_busy", i),  32'(busy4), 32'(tbl[i].gnt != '0));
      check($sformatf("tbl%0d_owner", i), 32'(own4),  32'(idx_of(tbl[i].gnt)));
    end

    // Sole requester keeps the bank across slot boundaries; owner data shows up one edge later.
    rst = 1'b0;
    req = 4'b0100;
    for (int k = 0; k < 24; k++) begin
      v    = 8'(k * 7 + 3);
      data = $urandom();
      data[23:16] = v;
      step();
      check($sformatf("hold%0d_gnt", k), 32'(gnt4), 32'h4);
      check($sformatf("hold%0d_ld", k),  32'(ld4),  32'(v));
    end

    // Fairness: 1,2,3 requesting; req[0] raised mid-slot of 2 waits until 3 finishes.
    data = FIXED;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      req = (k < 5) ? 4'b1110 : 4'b1111;
      step();
      ow = ((k / 4) + 1) % 4;
      check($sformatf("rr%0d_gnt", k), 32'(gnt4), 32'd1 << ow);
      check($sformatf("rr%0d_ld", k),  32'(ld4),  32'(pat(ow)));
    end

    // Owner 1 releases to 2; reset lands at cnt=3 of requester 2's slot.
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("pre_rst%0d_gnt", k), 32'(gnt4), 32'h4);
    end
    rst = 1'b1;
    req = 4'b0111;
    step();
    check("midrst_gnt",   32'(gnt4),  32'h0);
    check("midrst_busy",  32'(busy4), 32'h0);
    check("midrst_ld",    32'(ld4),   32'h00);
    check("midrst_owner", 32'(own4),  32'h0);
    rst = 1'b0;
    step();
    check("postrst_gnt", 32'(gnt4), 32'h1);
    check("postrst_ld",  32'(ld4),  32'h11);

    // HOLD=1 under contention rotates every edge.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("h1_%0d_gnt", k), 32'(gnt1), (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("h1_%0d_ld", k),  32'(ld1),  (k % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Random traffic, both instances against the model inside step().
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom());
      data = $urandom();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
